// File: rtl/cpu_reg_tx_pkg.sv
// Package: cpu_reg_tx_pkg
// Shared types and helpers for the CPU output-register UART transmitter.
//   DATA_W       width of the observed CPU register
//   tx_state_t   transmitter FSM states (PARITY only reachable when
//                REG_TX_PARITY_EN is defined)
//   even_parity  XOR reduction of a data byte (1 when the byte has an odd
//                number of ones, making the total count even)
package cpu_reg_tx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/reg_tx_fifo.sv
// Module: reg_tx_fifo
// Small synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write request; accepted when not full or popping this cycle
//   pop_i    in   read request; ignored when empty
//   din_i    in   write data
//   dout_o   out  oldest entry (valid while empty_o=0)
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
module reg_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then; the write lands on the slot being vacated.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    // Read is combinational so the FSM can load the byte on the pop cycle.
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_reg_uart_tx.sv
// Module: cpu_reg_uart_tx
// Watches the CPU output register, queues every new value and sends each
// one as a UART frame (8N1, or 8E1 when REG_TX_PARITY_EN is defined),
// LSB first.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset; aborts any frame at once
//   i_REG   in   CPU output register value, sampled every clk
//   o_TX    out  UART serial line, idles high (registered)
//   o_BUSY  out  FSM not IDLE or FIFO non-empty
//   o_OVF   out  sticky: a change was dropped on a full FIFO; cleared by rst
// Configuration macro: REG_TX_PARITY_EN (adds an even-parity bit time).
module cpu_reg_uart_tx
    import cpu_reg_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_REG,
    output logic              o_TX,
    output logic              o_BUSY,
    output logic              o_OVF
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] prev_q;
    logic              tx_q, tx_d;
    logic              ovf_q;
`ifdef REG_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_end;

    assign push    = (i_REG != prev_q);
    assign bit_end = (baud_q == BAUD_LAST);

    reg_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (i_REG),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef REG_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Baud counter only runs inside a frame; it sits at 0 in IDLE.
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
`ifdef REG_TX_PARITY_EN
                    par_d   = even_parity(fifo_dout);
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef REG_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef REG_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            prev_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef REG_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            // prev tracks the input even when the value is dropped.
            prev_q  <= i_REG;
            // o_TX is registered: it follows the FSM state by one clk.
            tx_q    <= tx_d;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
`ifdef REG_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_TX   = tx_q;
    assign o_BUSY = (state_q != IDLE) || !fifo_empty;
    assign o_OVF  = ovf_q;

endmodule

// File: tb/tb_cpu_reg_uart_tx.sv
module tb_cpu_reg_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef REG_TX_PARITY_EN
    localparam int FRAME_CYC = 11 * CLK_DIV;
`else
    localparam int FRAME_CYC = 10 * CLK_DIV;
`endif
    localparam int TIMEOUT = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] reg_v;
    logic       tx;
    logic       busy;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_reg_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_REG  (reg_v),
        .o_TX   (tx),
        .o_BUSY (busy),
        .o_OVF  (ovf)
    );

    task automatic check(input logic [63:0] observed, input logic [63:0] expected,
                         input string tag);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected o_TX per clk of one frame, index 0 = first low cycle.
    function automatic logic [63:0] build_frame(input logic [7:0] d);
        logic [63:0] f;
        int b;
        f = '1;
        for (int k = 0; k < FRAME_CYC; k++) begin
            b = k / CLK_DIV;
            if (b == 0)      f[k] = 1'b0;
            else if (b <= 8) f[k] = d[b-1];
`ifdef REG_TX_PARITY_EN
            else if (b == 9) f[k] = ^d;
`endif
            else             f[k] = 1'b1;
        end
        return f;
    endfunction

    task automatic capture(output logic [63:0] f, output logic [63:0] b);
        f = '1;
        b = '0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            f[k] = tx;
            b[k] = busy;
            tick();
        end
    endtask

    task automatic wait_frame(input logic [7:0] d, input string tag,
                              output logic [63:0] f);
        int n;
        logic [63:0] b;
        n = 0;
        f = '1;
        while (tx !== 1'b0 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({63'd0, n < TIMEOUT}, 64'd1, {tag, "_start"});
        if (n < TIMEOUT) begin
            capture(f, b);
            check(f, build_frame(d), tag);
            $display("frame %s: data %02h line %0h", tag, d, f);
        end
    endtask

    task automatic watch_idle(input int n, input string tag);
        logic seen_low;
        logic seen_busy;
        seen_low  = 1'b0;
        seen_busy = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (tx !== 1'b1)   seen_low  = 1'b1;
            if (busy !== 1'b0) seen_busy = 1'b1;
            tick();
        end
        check({63'd0, seen_low},  64'd0, {tag, "_tx_low"});
        check({63'd0, seen_busy}, 64'd0, {tag, "_busy"});
        $display("idle %s: %0d clk watched", tag, n);
    endtask

    logic [63:0] f;
    logic [63:0] b;
    logic [63:0] exp_busy;

    initial begin
        // 1. reset state and quiet line
        rst   = 1'b1;
        reg_v = 8'h00;
        repeat (3) tick();
        check({63'd0, tx},   64'd1, "rst_tx");
        check({63'd0, busy}, 64'd0, "rst_busy");
        check({63'd0, ovf},  64'd0, "rst_ovf");
        rst = 1'b0;
        watch_idle(100, "t1");

        // 2. 00 -> A5: two-edge latency, exact frame, busy fall
        reg_v = 8'hA5;
        tick();
        check({63'd0, tx},   64'd1, "t2_tx_edge1");
        check({63'd0, busy}, 64'd1, "t2_busy_edge1");
        tick();
        check({63'd0, tx},   64'd1, "t2_tx_edge2");
        tick();
        check({63'd0, tx},   64'd0, "t2_tx_edge3_low");
        capture(f, b);
        check(f, build_frame(8'hA5), "t2_frame");
        $display("frame t2: data a5 line %0h", f);
        exp_busy = '0;
        for (int k = 0; k < FRAME_CYC - 1; k++) exp_busy[k] = 1'b1;
        check(b, exp_busy, "t2_busy_profile");
        check({63'd0, tx}, 64'd1, "t2_tx_after");

        // 3. value held: no second frame
        watch_idle(200, "t3");

        // 4. six back-to-back changes into a 4-deep FIFO
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    reg_v = 8'(v);
                    tick();
                end
            end
            begin
                wait_frame(8'h01, "t4_f01", f);
            end
        join
        check({63'd0, ovf}, 64'd1, "t4_ovf_set");
        wait_frame(8'h02, "t4_f02", f);
        wait_frame(8'h03, "t4_f03", f);
        wait_frame(8'h04, "t4_f04", f);
        wait_frame(8'h05, "t4_f05", f);
        watch_idle(100, "t4_no_f06");
        check({63'd0, ovf}, 64'd1, "t4_ovf_sticky");

        // 5. reset mid-DATA with two values queued
        rst   = 1'b1;
        reg_v = 8'h00;
        tick();
        check({63'd0, ovf}, 64'd0, "t5_ovf_cleared");
        rst = 1'b0;
        reg_v = 8'h11; tick();
        reg_v = 8'h22; tick();
        reg_v = 8'h33; tick();
        check({63'd0, tx}, 64'd0, "t5_start_low");
        repeat (9) tick();
        check({63'd0, tx},   64'd0, "t5_data_bit1_low");
        check({63'd0, busy}, 64'd1, "t5_busy_before");
        rst   = 1'b1;
        reg_v = 8'h00;
        tick();
        check({63'd0, tx},   64'd1, "t5_tx_after_rst");
        check({63'd0, busy}, 64'd0, "t5_busy_after_rst");
        rst = 1'b0;
        watch_idle(150, "t5_no_frames");

        // 6. parity cases (plain frames in the 8N1 build)
        reg_v = 8'h07;
        wait_frame(8'h07, "t6_f07", f);
`ifdef REG_TX_PARITY_EN
        check({63'd0, f[9*CLK_DIV+1]}, 64'd1, "t6_par07");
`endif
        reg_v = 8'h03;
        wait_frame(8'h03, "t6_f03", f);
`ifdef REG_TX_PARITY_EN
        check({63'd0, f[9*CLK_DIV+1]}, 64'd0, "t6_par03");
`endif
        watch_idle(20, "t6_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
